div_seq_32: RTL and testbench
=============================

# div_seq_32

Sequential 32-bit signed divider for the datapath ALU; it executes DIV and writes its quotient/remainder pair into the Z register pair (quotient → Z low, remainder → Z high). It computes on operand magnitudes with a one-bit-per-cycle restoring loop. The signs are applied in a final fix-up step using two's-complement negation. A start/busy/done handshake lets the control unit stall until the result is ready.

## Interface
- DIV_ITER, 32: number of divide iterations, equal to the operand width.
- clk  in  1  rising-edge clock.
- clr  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- rA  in  32  dividend, signed two's complement.
- rB  in  32  divisor, signed two's complement.
- rZ_lo  out  32  quotient.
- rZ_hi  out  32  remainder.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the result is valid.
- div_by_zero  out  1  set with done when rB was 0; held until the next accepted start.

## Operation
- States: IDLE, DIVIDE, FIXUP, DONE.
- **IDLE**, start=1, rB≠0:
  - latch |rA| and |rB| into the working registers.
  - latch sign_q = rA[31]^rB[31] and sign_r = rA[31].
  - clear the iteration counter → DIVIDE.
- **IDLE**, start=1, rB=0:
  - → DONE with rZ_lo=32'hFFFFFFFF, rZ_hi=rA, div_by_zero=1.
- **DIVIDE**, one iteration per cycle:
  - {rem,quo} shifted left by 1; trial = rem − |rB| on 33 bits.
  - If trial is non-negative, rem=trial and quo[0]=1; otherwise quo[0]=0.
  - After DIV_ITER iterations (counter 0..31) → FIXUP.
- **FIXUP**:
  - rZ_lo = sign_q ? −quo : quo.
  - rZ_hi = sign_r ? −rem : rem.
  - → DONE.
- **DONE**: done=1 for one cycle → IDLE.
- Semantics:
  - Truncation toward zero; remainder takes the sign of the dividend.
  - Magnitudes are unsigned 32-bit values, so |−2^31| = 32'h80000000 is exact.
  - 32'h80000000 / 32'hFFFFFFFF gives quotient 32'h80000000 (wraps) and remainder 0; no overflow flag.
- start outside IDLE is ignored: no queuing, no restart.
- Operands are latched at accept; later changes to rA/rB have no effect.
- rZ_lo, rZ_hi and div_by_zero hold their values in IDLE until the next accepted start.

## Timing
- Reset (clr=0, at any time, including mid-divide):
  - state=IDLE; rZ_lo, rZ_hi, busy, done, div_by_zero all 0.
  - Working registers and counter are cleared; no partial result becomes visible.
- Accept at edge N (state IDLE, start=1):
  - busy=1 from after edge N until the edge that leaves DONE.
  - Normal path: DIVIDE occupies edges N+1..N+32, FIXUP result registered at edge N+33, done=1 in the cycle after edge N+33. Latency is 34 cycles.
  - Divide-by-zero path: done=1 in the cycle after edge N+1.
- Outputs are registered; no combinational path from inputs to outputs.
- The earliest next accept is the edge at which DONE returns to IDLE.

## Structure
- Shared package cpu_pkg:
  - DIV_ITER.
  - The 2-bit state encoding: IDLE=0, DIVIDE=1, FIXUP=2, DONE=3.
- Sub-module: the existing neg_32 two's-complement block.
  - Instantiated twice for input magnitudes (muxed on the sign bit).
  - Instantiated twice for output sign fix-up.
- The subtract/shift datapath, counter and FSM are local to div_seq_32.

## Test plan
- rA=100, rB=7, start at cycle 0 → done at cycle 34, rZ_lo=14, rZ_hi=2, div_by_zero=0.
- rA=−100 (32'hFFFFFF9C), rB=7 → rZ_lo=32'hFFFFFFF2 (−14), rZ_hi=32'hFFFFFFFE (−2). Also rA=100, rB=−7 → rZ_lo=−14, rZ_hi=2.
- rA=32'h80000000, rB=32'hFFFFFFFF → rZ_lo=32'h80000000, rZ_hi=0, latency 34.
- rA=5, rB=0 → done 2 cycles after start, rZ_lo=32'hFFFFFFFF, rZ_hi=5, div_by_zero=1. A following 9/3 clears div_by_zero and gives rZ_lo=3, rZ_hi=0.
- Start 100/7, pulse start with 50/5 at cycle 10 → second start ignored, result 14/2 at cycle 34.
- Start 100/7, assert clr at cycle 10 → busy, done and outputs all 0 immediately. After release, start 50/5 → rZ_lo=10, rZ_hi=0 with full 34-cycle latency.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: divider iteration count and divider FSM encoding.
`default_nettype none

package cpu_pkg;

  localparam int DIV_ITER = 32;
  localparam int CNT_W    = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2,
    DONE   = 2'd3
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/neg_32.sv
// Two's-complement negation of a 32-bit value.
`default_nettype none

module neg_32 (
  input  logic [31:0] a_i,
  output logic [31:0] y_o
);

  assign y_o = ~a_i + 32'd1;

endmodule

`default_nettype wire

// File: rtl/div_seq_32.sv
// Sequential signed 32-bit divider: restoring loop on magnitudes, sign fix-up at the end.
`default_nettype none

module div_seq_32
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] rA,
  input  logic [31:0] rB,
  output logic [31:0] rZ_lo,
  output logic [31:0] rZ_hi,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      dvs_q, dvs_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic             zero_q, zero_d;
  logic [31:0]      zlo_q, zlo_d;
  logic [31:0]      zhi_q, zhi_d;
  logic             dbz_q, dbz_d;

  logic [31:0] neg_a, neg_b, neg_quo, neg_rem;
  logic [31:0] mag_a, mag_b;
  logic [32:0] shift, trial;

  neg_32 u_neg_a   (.a_i(rA),    .y_o(neg_a));
  neg_32 u_neg_b   (.a_i(rB),    .y_o(neg_b));
  neg_32 u_neg_quo (.a_i(quo_q), .y_o(neg_quo));
  neg_32 u_neg_rem (.a_i(rem_q), .y_o(neg_rem));

  assign mag_a = rA[31] ? neg_a : rA;
  assign mag_b = rB[31] ? neg_b : rB;

  // |divisor| <= 2^31 keeps rem below 2^31, so the shifted value fits 32 bits and bit 32 is the sign.
  assign shift = {rem_q, quo_q[31]};
  assign trial = shift - {1'b0, dvs_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    zero_d   = zero_q;
    zlo_d    = zlo_q;
    zhi_d    = zhi_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          cnt_d = '0;
          if (rB == 32'd0) begin
            // Reuse the fix-up step with positive signs to publish the fixed divide-by-zero result.
            rem_d    = rA;
            quo_d    = 32'hFFFF_FFFF;
            dvs_d    = 32'd0;
            sign_q_d = 1'b0;
            sign_r_d = 1'b0;
            zero_d   = 1'b1;
            state_d  = FIXUP;
          end else begin
            rem_d    = 32'd0;
            quo_d    = mag_a;
            dvs_d    = mag_b;
            sign_q_d = rA[31] ^ rB[31];
            sign_r_d = rA[31];
            zero_d   = 1'b0;
            state_d  = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        rem_d = trial[32] ? shift[31:0] : trial[31:0];
        quo_d = {quo_q[30:0], ~trial[32]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_ITER - 1)) state_d = FIXUP;
      end
      FIXUP: begin
        zlo_d   = sign_q_q ? neg_quo : quo_q;
        zhi_d   = sign_r_q ? neg_rem : rem_q;
        dbz_d   = zero_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      zero_q   <= 1'b0;
      zlo_q    <= 32'd0;
      zhi_q    <= 32'd0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      zero_q   <= zero_d;
      zlo_q    <= zlo_d;
      zhi_q    <= zhi_d;
      dbz_q    <= dbz_d;
    end
  end

  assign rZ_lo       = zlo_q;
  assign rZ_hi       = zhi_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_div_seq_32.sv
// Directed self-checking bench for div_seq_32.
`default_nettype none

module tb_div_seq_32;

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] rA;
  logic [31:0] rB;
  logic [31:0] rZ_lo;
  logic [31:0] rZ_hi;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  div_seq_32 dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .rA         (rA),
    .rB         (rB),
    .rZ_lo      (rZ_lo),
    .rZ_hi      (rZ_hi),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive operands in the cycle before the accept edge; returns after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rA    = a;
    rB    = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rA    = 32'hDEAD_BEEF;
    rB    = 32'h0000_0003;
  endtask

  // Waits for done; lat counts the start cycle plus edges after accept.
  task automatic wait_done(output int lat);
    lat = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: done never asserted");
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                     input logic exp_dbz, input int exp_lat);
    int lat;
    issue(a, b);
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    wait_done(lat);
    check({tag, " lat"}, lat, exp_lat);
    check({tag, " lo"}, rZ_lo, exp_lo);
    check({tag, " hi"}, rZ_hi, exp_hi);
    check({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, {30'd0, busy, done}, 32'd0);
    check({tag, " hold lo"}, rZ_lo, exp_lo);
  endtask

  initial begin
    int lat;
    clr   = 1'b0;
    start = 1'b0;
    rA    = 32'd0;
    rB    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset lo", rZ_lo, 32'd0);
    check("reset hi", rZ_hi, 32'd0);
    check("reset flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    @(negedge clk);
    clr = 1'b1;

    run("100/7",   32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 34);
    run("-100/7",  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
    run("100/-7",  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0, 34);
    run("min/-1",  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 34);
    run("5/0",     32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1, 2);
    run("9/3",     32'd9,         32'd3,         32'd3,         32'd0,         1'b0, 34);

    // A second start during a divide must be ignored.
    issue(32'd100, 32'd7);
    lat = 1;
    repeat (9) begin
      @(posedge clk);
      lat++;
    end
    @(negedge clk);
    rA    = 32'd50;
    rB    = 32'd5;
    start = 1'b1;
    @(posedge clk);
    lat++;
    #1;
    start = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ignore lat", lat, 34);
    check("ignore lo", rZ_lo, 32'd14);
    check("ignore hi", rZ_hi, 32'd2);
    @(posedge clk);
    #1;
    check("ignore idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a divide.
    issue(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #2;
    clr = 1'b0;
    #1;
    check("midclr lo", rZ_lo, 32'd0);
    check("midclr hi", rZ_hi, 32'd0);
    check("midclr flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    run("50/5", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
